power_sqrt: RTL and testbench



---
 rtl/fft_pkg.sv | 20 ++
 rtl/power_sqrt_sqrt_step.sv | 44 ++++
 rtl/power_sqrt.sv | 143 ++++++++++++++
 tb/tb_power_sqrt.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
//------------------------------------------------------------------------------
// fft_pkg
// Declarations shared by the FFT peripheral stages:
//   POWER_W      - width of a magnitude-squared (power) word
//   MAG_W        - width of a magnitude word
//   sqrt_state_t - state encoding of the power_sqrt stage (IDLE/CALC/DONE)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package fft_pkg;

   localparam int POWER_W = 32;
   localparam int MAG_W   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sqrt_state_t;

endpackage

// File: rtl/power_sqrt_sqrt_step.sv
//------------------------------------------------------------------------------
// sqrt_step
// One digit step of the digit-by-digit integer square root. The step appends
// the next two radicand bits to the partial remainder and tries to subtract
// the trial value (root<<2)|1.
// Ports:
//   rem       - partial remainder in (OUT_W+2 bits)
//   root      - partial root in (OUT_W bits)
//   bits      - next two radicand bits, most significant first
//   rem_next  - partial remainder out
//   root_next - partial root out (one more resolved bit)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sqrt_step #(
   parameter int OUT_W = 16
) (
   input  logic [OUT_W+1:0] rem,
   input  logic [OUT_W-1:0] root,
   input  logic [1:0]       bits,
   output logic [OUT_W+1:0] rem_next,
   output logic [OUT_W-1:0] root_next
);

   logic [OUT_W+1:0] rem_sh_s;
   logic [OUT_W+1:0] trial_s;
   logic             fits_s;

   // Trial subtraction for one root bit. The remainder never exceeds 2*root,
   // and root has at most OUT_W-1 bits before the last step, so dropping the
   // top two remainder bits on the shift loses nothing.
   always_comb begin
      rem_sh_s = {rem[OUT_W-1:0], bits};
      trial_s  = {root, 2'b01};
      fits_s   = (rem_sh_s >= trial_s);
      if (fits_s) begin
         rem_next  = rem_sh_s - trial_s;
         root_next = {root[OUT_W-2:0], 1'b1};
      end else begin
         rem_next  = rem_sh_s;
         root_next = {root[OUT_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/power_sqrt.sv
//------------------------------------------------------------------------------
// power_sqrt
// Streaming integer square root after the magnitude-squared stage: converts a
// DATA_W-bit power word into an OUT_W = DATA_W/2 bit magnitude, resolving
// BITS_PER_CYCLE root bits per clock. One word is in flight at a time; the
// result sits in a single output register until downstream takes it.
// Ports:
//   i_clk, i_rst_n  - clock, synchronous active-low reset
//   i_data          - radicand (power), DATA_W bits
//   i_data_valid    - upstream word valid
//   o_data_ready    - high only in IDLE and out of reset
//   o_data          - root, OUT_W bits
//   o_data_valid    - result valid, held until i_data_ready
//   i_data_ready    - downstream accepts result
// Build option:
//   POWER_SQRT_ROUND_EN - round to nearest (saturating) instead of floor.
// DATA_W must be even and >= 4; BITS_PER_CYCLE is 1 or 2 and divides OUT_W.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module power_sqrt
   import fft_pkg::*;
#(
   parameter int DATA_W         = POWER_W,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [DATA_W-1:0]   i_data,
   input  logic                i_data_valid,
   output logic                o_data_ready,
   output logic [DATA_W/2-1:0] o_data,
   output logic                o_data_valid,
   input  logic                i_data_ready
);

   localparam int OUT_W  = DATA_W / 2;
   localparam int REM_W  = OUT_W + 2;
   localparam int ITERS  = OUT_W / BITS_PER_CYCLE;
   localparam int ITER_W = $clog2(ITERS + 1);
   localparam int SH_W   = 2 * BITS_PER_CYCLE;

   sqrt_state_t       state_r;
   logic [DATA_W-1:0] rad_r;
   logic [OUT_W-1:0]  root_r;
   logic [REM_W-1:0]  rem_r;
   logic [ITER_W-1:0] iter_r;
   logic [OUT_W-1:0]  o_data_r;
   logic              o_data_valid_r;

   logic [REM_W-1:0]  rem_a_s;
   logic [OUT_W-1:0]  root_a_s;
   logic [REM_W-1:0]  rem_fin_s;
   logic [OUT_W-1:0]  root_fin_s;
   logic [OUT_W-1:0]  result_s;

   // First digit step always consumes the top two radicand bits.
   sqrt_step #(.OUT_W(OUT_W)) u_step0 (
      .rem       (rem_r),
      .root      (root_r),
      .bits      (rad_r[DATA_W-1 -: 2]),
      .rem_next  (rem_a_s),
      .root_next (root_a_s)
   );

   if (BITS_PER_CYCLE == 2) begin : g_two_steps
      sqrt_step #(.OUT_W(OUT_W)) u_step1 (
         .rem       (rem_a_s),
         .root      (root_a_s),
         .bits      (rad_r[DATA_W-3 -: 2]),
         .rem_next  (rem_fin_s),
         .root_next (root_fin_s)
      );
   end else begin : g_one_step
      assign rem_fin_s  = rem_a_s;
      assign root_fin_s = root_a_s;
   end

`ifdef POWER_SQRT_ROUND_EN
   // Round to nearest: n >= (r+0.5)^2 reduces to rem > root for integers;
   // an all-ones root saturates instead of wrapping.
   always_comb begin
      if ((rem_fin_s > {2'b00, root_fin_s}) && (root_fin_s != {OUT_W{1'b1}})) begin
         result_s = root_fin_s + {{(OUT_W-1){1'b0}}, 1'b1};
      end else begin
         result_s = root_fin_s;
      end
   end
`else
   assign result_s = root_fin_s;
`endif

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r        <= IDLE;
         rad_r          <= {DATA_W{1'b0}};
         root_r         <= {OUT_W{1'b0}};
         rem_r          <= {REM_W{1'b0}};
         iter_r         <= {ITER_W{1'b0}};
         o_data_r       <= {OUT_W{1'b0}};
         o_data_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_data_valid) begin
                  rad_r   <= i_data;
                  root_r  <= {OUT_W{1'b0}};
                  rem_r   <= {REM_W{1'b0}};
                  iter_r  <= ITER_W'(ITERS);
                  state_r <= CALC;
               end
            end
            CALC: begin
               rem_r  <= rem_fin_s;
               root_r <= root_fin_s;
               rad_r  <= {rad_r[DATA_W-SH_W-1:0], {SH_W{1'b0}}};
               iter_r <= iter_r - ITER_W'(1);
               if (iter_r == ITER_W'(1)) begin
                  o_data_r       <= result_s;
                  o_data_valid_r <= 1'b1;
                  state_r        <= DONE;
               end
            end
            DONE: begin
               if (i_data_ready) begin
                  o_data_valid_r <= 1'b0;
                  state_r        <= IDLE;
               end
            end
            default: begin
               o_data_valid_r <= 1'b0;
               state_r        <= IDLE;
            end
         endcase
      end
   end

   // Ready depends on state and reset only, never on i_data_ready.
   assign o_data_ready = (state_r == IDLE) && i_rst_n;
   assign o_data       = o_data_r;
   assign o_data_valid = o_data_valid_r;

endmodule

// File: tb/tb_power_sqrt.sv
`timescale 1ns/1ps
module tb_power_sqrt;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] din;
   logic        din_valid;
   logic        o_rdy;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   power_sqrt #(.DATA_W(32), .BITS_PER_CYCLE(1)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data       (din),
      .i_data_valid (din_valid),
      .o_data_ready (o_rdy),
      .o_data       (dout),
      .o_data_valid (dout_valid),
      .i_data_ready (dout_ready)
   );

   typedef struct {
      logic [31:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[7];

   // Reference: largest r with r*r <= n, optionally rounded to nearest.
   function automatic logic [15:0] ref_sqrt(input logic [31:0] n);
      longint unsigned lo, hi, mid, nn;
      nn = longint'(n);
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= nn) lo = mid;
         else hi = mid - 1;
      end
`ifdef POWER_SQRT_ROUND_EN
      if ((nn - lo * lo > lo) && (lo < 65535)) lo = lo + 1;
`endif
      return lo[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!o_rdy && n < 60) begin
         tick();
         n++;
      end
      chk("wait_ready", {31'd0, o_rdy}, 32'd1);
   endtask

   // Apply one word with downstream always ready; checks latency, value,
   // ready low while busy, and return to IDLE after the transfer.
   task automatic do_vec(input string name, input logic [31:0] d, input logic [15:0] exp);
      int lat = 0;
      int busy_bad = 0;
      wait_ready();
      din        = d;
      din_valid  = 1'b1;
      dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      din       = $urandom;
      while (!dout_valid && lat < 40) begin
         if (o_rdy) busy_bad++;
         tick();
         lat++;
      end
      if (o_rdy) busy_bad++;
      chk({name, "_latency"}, lat, 32'd16);
      chk({name, "_value"}, {16'd0, dout}, {16'd0, exp});
      chk({name, "_ready_low"}, busy_bad, 32'd0);
      tick();
      chk({name, "_handshake"}, {30'd0, dout_valid, o_rdy}, 32'd1);
   endtask

   initial begin
      int lat;
      int bad;
      int seen;
      int sent;
      int got;
      int gap;
      int cyc;
      logic pending;
      logic new_ready;
      logic [31:0] pend_data;
      logic [31:0] r;
      logic [15:0] exp_q[$];

      vecs[0] = '{32'd0,          16'd0};
      vecs[1] = '{32'd1,          16'd1};
      vecs[2] = '{32'd25,         16'd5};
      vecs[3] = '{32'h3FFF0001,   16'h7FFF};
      vecs[4] = '{32'hFFFFFFFF,   16'hFFFF};
`ifdef POWER_SQRT_ROUND_EN
      vecs[5] = '{32'd3,          16'd2};
`else
      vecs[5] = '{32'd3,          16'd1};
`endif
      vecs[6] = '{32'd2,          16'd1};

      rst_n      = 1'b0;
      din        = 32'd0;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      repeat (3) tick();
      chk("reset_ready", {31'd0, o_rdy}, 32'd0);
      chk("reset_valid", {31'd0, dout_valid}, 32'd0);
      chk("reset_data", {16'd0, dout}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_reset_ready", {31'd0, o_rdy}, 32'd1);

      for (int i = 0; i < 7; i++) begin
         do_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp);
      end

      // Back-pressure: result held 10 cycles, upstream valid ignored.
      wait_ready();
      din        = 32'h00010000;
      din_valid  = 1'b1;
      dout_ready = 1'b0;
      tick();
      din_valid = 1'b0;
      lat = 0;
      while (!dout_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("bp_latency", lat, 32'd16);
      chk("bp_first", {16'd0, dout}, 32'd256);
      din       = 32'd49;
      din_valid = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (dout_valid !== 1'b1 || dout !== 16'd256 || o_rdy !== 1'b0) bad++;
      end
      chk("bp_hold", bad, 32'd0);
      dout_ready = 1'b1;
      tick();
      chk("bp_release_idle", {30'd0, dout_valid, o_rdy}, 32'd1);
      chk("bp_keep_data", {16'd0, dout}, 32'd256);
      tick();
      din_valid = 1'b0;
      chk("bp_accept_later", {31'd0, o_rdy}, 32'd0);
      lat = 0;
      while (!dout_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("bp_second_latency", lat, 32'd16);
      chk("bp_second_value", {16'd0, dout}, 32'd7);
      tick();
      chk("bp_single_transfer", {30'd0, dout_valid, o_rdy}, 32'd1);

      // Reset in the middle of CALC abandons the word.
      wait_ready();
      din        = 32'hFFFF0000;
      din_valid  = 1'b1;
      dout_ready = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (8) tick();
      chk("mid_busy", {31'd0, o_rdy}, 32'd0);
      rst_n = 1'b0;
      tick();
      chk("mid_reset_outs", {14'd0, dout_valid, o_rdy, dout}, 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (dout_valid) seen++;
      end
      chk("mid_no_stale", seen, 32'd0);
      do_vec("after_reset", 32'd144, 16'd12);

      // Randomized stream with gaps and back-pressure against the model.
      sent    = 0;
      got     = 0;
      gap     = 0;
      cyc     = 0;
      pending = 1'b0;
      pend_data = 32'd0;
      while (got < 1000 && cyc < 60000) begin
         new_ready = ($urandom_range(0, 3) != 0);
         if (!pending && sent < 1000) begin
            if (gap > 0) begin
               gap--;
            end else begin
               pending = 1'b1;
               case ($urandom_range(0, 3))
                  0: pend_data = $urandom;
                  1: pend_data = $urandom_range(0, 1000);
                  2: begin
                     r = $urandom_range(0, 65535);
                     pend_data = r * r + $urandom_range(0, 2 * r);
                  end
                  default: pend_data = 32'hFFFFFFFF - $urandom_range(0, 1000);
               endcase
            end
         end
         din_valid  = pending;
         din        = pending ? pend_data : $urandom;
         dout_ready = new_ready;
         if (dout_valid && new_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rand_extra: got unexpected result %0h, expected none", dout);
            end else begin
               chk("rand_data", {16'd0, dout}, {16'd0, exp_q.pop_front()});
            end
            got++;
         end
         if (o_rdy && pending) begin
            exp_q.push_back(ref_sqrt(pend_data));
            sent++;
            pending = 1'b0;
            gap = $urandom_range(0, 3);
         end
         tick();
         cyc++;
      end
      din_valid = 1'b0;
      chk("rand_count", got, 32'd1000);
      chk("rand_queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
